// File: rtl/instr_fetch_pkg.sv
// Shared constants, opcode helpers and FSM state type for the instruction fetch unit.
package instr_fetch_pkg;

  localparam int          INSTR_W  = 16;
  localparam int          OPCODE_W = 4;
  localparam logic [3:0]  OP_NOP   = 4'h0;
  localparam logic [3:0]  OP_HALT  = 4'hF;
  localparam logic [15:0] NOP_WORD = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    HALTED
  } fetch_state_t;

  function automatic logic is_halt(input logic [INSTR_W-1:0] word);
    return word[INSTR_W-1 -: OPCODE_W] == OP_HALT;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Synchronous FIFO for fetched instruction words, with a synchronous flush.
module instr_fifo
  import instr_fetch_pkg::*;
#(
  parameter int WIDTH = INSTR_W,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             wr_en, rd_en;

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign rdata = mem_q[rd_ptr_q];

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    wr_en    = push && !full && !clear;
    rd_en    = pop && !empty && !clear;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: pc, credit-limited memory requests, response filtering at HALT,
// and an instruction FIFO presented to the processor with NOP fill when empty.
module instr_fetch_unit
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_pc,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [ADDR_W-1:0]  req_addr,
  input  logic               rsp_valid,
  input  logic [INSTR_W-1:0] rsp_data,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               busy,
  output logic               halted,
  output logic [ADDR_W-1:0]  pc
);

  localparam int             CNT_W        = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W+1)'(DEPTH);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  out_q, out_d;

  logic [INSTR_W-1:0] fifo_rdata;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty, fifo_full;
  logic               fifo_push, fifo_pop, fifo_clear;

  logic [CNT_W:0] credits_used;
  logic           req_fire, rsp_accept, rsp_is_halt;

  // Buffered words plus in-flight requests may never exceed the FIFO depth,
  // so every accepted response is guaranteed a free slot.
  assign credits_used = {1'b0, fifo_count} + {1'b0, out_q};
  assign req_valid    = (state_q == FETCH) && (credits_used < CREDIT_LIMIT) && !fifo_full;
  assign req_addr     = pc_q;
  assign pc           = pc_q;
  assign req_fire     = req_valid && req_ready;

  // A response with nothing outstanding is stale (e.g. issued before a reset) and is dropped.
  assign rsp_accept  = rsp_valid && (out_q != '0);
  assign rsp_is_halt = is_halt(rsp_data);
  assign fifo_push   = rsp_accept && (state_q == FETCH) && !rsp_is_halt;
  assign fifo_pop    = instr_valid && instr_ready;

  assign instr_valid = !fifo_empty;
  assign instruction = instr_valid ? fifo_rdata : NOP_WORD;
  assign busy        = (state_q == FETCH) || (state_q == DRAIN);
  assign halted      = (state_q == HALTED);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fifo_clear = 1'b0;
    case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          state_d    = FETCH;
          pc_d       = start_pc;
          fifo_clear = 1'b1;
        end
      end
      FETCH: begin
        if (req_fire) pc_d = pc_q + ADDR_W'(1);
        if (rsp_accept && rsp_is_halt) state_d = DRAIN;
      end
      DRAIN: begin
        // Words fetched past the HALT are swallowed here; buffered ones still drain out.
        if ((out_q == '0) && fifo_empty) state_d = HALTED;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_d = out_q;
    case ({req_fire, rsp_accept})
      2'b10:   out_d = out_q + CNT_W'(1);
      2'b01:   out_d = out_q - CNT_W'(1);
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
    end
  end

  instr_fifo #(
    .WIDTH(INSTR_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .clear(fifo_clear),
    .push (fifo_push),
    .pop  (fifo_pop),
    .wdata(rsp_data),
    .rdata(fifo_rdata),
    .count(fifo_count),
    .empty(fifo_empty),
    .full (fifo_full)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: cycle table for the basic fetch plus hand-written
// back-pressure, HALT, wrap/stall, reset and stale-response sequences against a memory model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  start_pc;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_addr;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [15:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic        busy;
  logic        halted;
  logic [7:0]  pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_pc   (start_pc),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .instruction(instruction),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .busy       (busy),
    .halted     (halted),
    .pc         (pc)
  );

  // Memory model: fixed latency, in-order; manual drive replaces it when mem_en is low.
  logic [15:0] mem [256];
  int          mem_lat;
  bit          mem_en;
  logic        mem_rsp_valid;
  logic [15:0] mem_rsp_data;
  logic        man_valid;
  logic [15:0] man_data;

  typedef struct {
    logic [15:0] data;
    int          due;
  } pend_t;
  pend_t pend_q[$];
  int    cyc;

  assign rsp_valid = mem_en ? mem_rsp_valid : man_valid;
  assign rsp_data  = mem_en ? mem_rsp_data  : man_data;

  initial begin : mem_model
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 16'h0000;
    cyc = 0;
    forever begin
      @(negedge clk);
      #1;
      mem_rsp_valid = 1'b0;
      if (rst || !mem_en) begin
        pend_q.delete();
      end else begin
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = pend_q[0].data;
          pend_q.delete(0);
        end
        if (req_valid && req_ready) pend_q.push_back('{mem[req_addr], cyc + mem_lat});
      end
      cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_halted(input string name);
    int n = 0;
    while (!halted && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(halted), 32'd1);
  endtask

  typedef struct {
    logic        start;
    logic [7:0]  start_pc;
    logic        exp_req_valid;
    logic [7:0]  exp_req_addr;
    logic        exp_instr_valid;
    logic [15:0] exp_instr;
    logic        exp_busy;
    logic        exp_halted;
  } vec_t;

  vec_t        vecs [9];
  logic [15:0] got [$];
  logic [7:0]  addrs [$];
  logic [7:0]  hold_pc;
  bit          hold_pending;
  int          n_req;
  int          lat;

  initial begin
    vecs[0] = '{1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 8'h10, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 8'h12, 1'b1, 16'h1248, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 8'h13, 1'b1, 16'h2248, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 8'h14, 1'b1, 16'h3248, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 8'h15, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 8'h15, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 8'h15, 1'b0, 16'h0000, 1'b0, 1'b1};

    for (int i = 0; i < 256; i++) mem[i] = 16'h7777;
    mem[8'h10] = 16'h1248; mem[8'h11] = 16'h2248; mem[8'h12] = 16'h3248;
    mem[8'h13] = 16'hF000; mem[8'h14] = 16'h5555;
    for (int i = 0; i < 8; i++) mem[8'h20 + i] = 16'h1020 + 16'(i);
    mem[8'h28] = 16'hF000;
    mem[8'h00] = 16'h1248; mem[8'h01] = 16'hF000; mem[8'h02] = 16'h2248;
    mem[8'h40] = 16'hF000;
    mem[8'hFE] = 16'h1111; mem[8'hFF] = 16'h2222;
    mem[8'h60] = 16'hABCD; mem[8'h61] = 16'hF000;

    rst = 1'b1; start = 1'b0; start_pc = 8'h00; req_ready = 1'b1; instr_ready = 1'b1;
    mem_en = 1'b1; mem_lat = 1; man_valid = 1'b0; man_data = 16'h0000;

    // Reset state
    #1;
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_req_addr", 32'(req_addr), 32'd0);
    check("rst_instruction", 32'(instruction), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic fetch, one vector per cycle, cycle 0 = start
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check($sformatf("v%0d_req_valid", i), 32'(req_valid), 32'(vecs[i].exp_req_valid));
      check($sformatf("v%0d_req_addr", i), 32'(req_addr), 32'(vecs[i].exp_req_addr));
      check($sformatf("v%0d_instr_valid", i), 32'(instr_valid), 32'(vecs[i].exp_instr_valid));
      check($sformatf("v%0d_instruction", i), 32'(instruction), 32'(vecs[i].exp_instr));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      check($sformatf("v%0d_halted", i), 32'(halted), 32'(vecs[i].exp_halted));
      start    = vecs[i].start;
      start_pc = vecs[i].start_pc;
    end

    // Back-pressure: consumer stalled, credits run out after DEPTH requests
    @(negedge clk);
    instr_ready = 1'b0; start = 1'b1; start_pc = 8'h20;
    n_req = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (req_valid && req_ready) n_req++;
    end
    check("bp_req_count", 32'(n_req), 32'd4);
    check("bp_req_valid_low", 32'(req_valid), 32'd0);
    check("bp_instr_valid", 32'(instr_valid), 32'd1);
    check("bp_head", 32'(instruction), 32'h1020);
    instr_ready = 1'b1;
    got.delete();
    got.push_back(instruction);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) check("bp_credit_return", 32'(req_valid), 32'd1);
      if (instr_valid) got.push_back(instruction);
      if (halted) break;
    end
    check("bp_halted", 32'(halted), 32'd1);
    check("bp_word_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      check($sformatf("bp_word%0d", i), 32'(got[i]), 32'h1020 + 32'(i));

    // HALT with 3-cycle memory: only the word before HALT executes
    mem_lat = 3;
    start = 1'b1; start_pc = 8'h00;
    got.delete();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (instr_valid) got.push_back(instruction);
      if (halted) break;
    end
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_word_count", 32'(got.size()), 32'd1);
    if (got.size() > 0) check("halt_word0", 32'(got[0]), 32'h1248);
    start = 1'b1; start_pc = 8'h40;
    @(negedge clk);
    start = 1'b0;
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_halted", 32'(halted), 32'd0);
    check("restart_req_valid", 32'(req_valid), 32'd1);
    check("restart_req_addr", 32'(req_addr), 32'h40);
    wait_halted("restart_halt_done");

    // Wrap and stall: req_ready toggles, pc must hold on refused requests
    mem_lat = 1;
    req_ready = 1'b0; start = 1'b1; start_pc = 8'hFE;
    addrs.delete();
    hold_pending = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (hold_pending) check("wrap_pc_hold", 32'(pc), 32'(hold_pc));
      hold_pending = 1'b0;
      req_ready = ~req_ready;
      if (req_valid) begin
        if (req_ready) begin
          if (addrs.size() < 4) addrs.push_back(req_addr);
        end else begin
          hold_pc = pc;
          hold_pending = 1'b1;
        end
      end
    end
    req_ready = 1'b1;
    check("wrap_addr_count", 32'(addrs.size()), 32'd4);
    if (addrs.size() == 4) begin
      check("wrap_addr0", 32'(addrs[0]), 32'hFE);
      check("wrap_addr1", 32'(addrs[1]), 32'hFF);
      check("wrap_addr2", 32'(addrs[2]), 32'h00);
      check("wrap_addr3", 32'(addrs[3]), 32'h01);
    end
    wait_halted("wrap_halt_done");

    // Reset mid-fetch with 2 outstanding and 1 buffered word
    mem_lat = 3;
    instr_ready = 1'b0; start = 1'b1; start_pc = 8'h50;
    n_req = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      req_ready = (n_req < 3);
      if (req_valid && req_ready) n_req++;
      if (instr_valid) break;
    end
    check("pre_rst_buffered", 32'(instr_valid), 32'd1);
    #2;
    rst = 1'b1;
    mem_en = 1'b0;
    #1;
    check("mid_rst_req_valid", 32'(req_valid), 32'd0);
    check("mid_rst_req_addr", 32'(req_addr), 32'd0);
    check("mid_rst_instruction", 32'(instruction), 32'd0);
    check("mid_rst_instr_valid", 32'(instr_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_halted", 32'(halted), 32'd0);
    check("mid_rst_pc", 32'(pc), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req_ready = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      man_valid = 1'b1; man_data = 16'h2248;
    end
    @(negedge clk);
    man_valid = 1'b0;
    check("late_rsp_instr_valid", 32'(instr_valid), 32'd0);
    check("late_rsp_busy", 32'(busy), 32'd0);
    check("late_rsp_halted", 32'(halted), 32'd0);

    // Spurious response in IDLE
    man_valid = 1'b1; man_data = 16'h1248;
    @(negedge clk);
    man_valid = 1'b0;
    @(negedge clk);
    check("spurious_instr_valid", 32'(instr_valid), 32'd0);
    check("spurious_instruction", 32'(instruction), 32'd0);
    check("spurious_req_valid", 32'(req_valid), 32'd0);

    // Clean restart after reset: first word at cycle 3
    mem_en = 1'b1; mem_lat = 1;
    start = 1'b1; start_pc = 8'h60;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (instr_valid) break;
    end
    check("post_rst_latency", 32'(lat), 32'd3);
    check("post_rst_word", 32'(instruction), 32'hABCD);
    wait_halted("post_rst_halt_done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Producer side of the processor's 16-bit instruction input.
- Holds the program counter and issues in-order read requests to instruction memory over a valid/ready request channel and a valid-only response channel.
- Buffers returned words in a small FIFO and presents them to the processor with an instr_valid/instr_ready handshake.
- Emits NOP (16'h0000) when it has nothing to present, and stops fetching at a HALT word.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; pc wraps modulo 2^ADDR_W.
- DEPTH, 4, instruction FIFO depth and maximum number of outstanding memory requests; power of two, at least 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; loads pc from start_pc and begins fetching.
- start_pc  input  ADDR_W  first fetch address, sampled when start is accepted.
- req_valid  output  1  memory read request valid.
- req_ready  input  1  memory accepts the request this cycle.
- req_addr  output  ADDR_W  read address; equals pc.
- rsp_valid  input  1  read data returned; responses arrive in request order with latency of 1 or more cycles.
- rsp_data  input  16  returned instruction word.
- instruction  output  16  FIFO head when instr_valid is high, else 16'h0000.
- instr_valid  output  1  instruction is a real fetched word.
- instr_ready  input  1  consumer takes the word; the processor ties this to 1.
- busy  output  1  high in FETCH or DRAIN.
- halted  output  1  high in HALTED.
- pc  output  ADDR_W  next address to request.

Behaviour:
- Reset (async assert, sync release): state IDLE; pc 0; outstanding 0; FIFO empty.
  - All outputs 0: req_valid, req_addr, instruction, instr_valid, busy, halted.
  - Reset mid-operation drops all buffered words and forgets in-flight requests; any later rsp_valid is discarded.
- State IDLE: start loads pc <= start_pc and moves to FETCH. Otherwise the block stays idle.
- State FETCH:
  - req_valid = (fifo_count + outstanding < DEPTH).
  - On req_valid && req_ready: pc <= pc + 1 (wraps) and outstanding increments.
  - start is ignored.
- Response handling:
  - On rsp_valid with outstanding > 0: outstanding decrements.
  - If rsp_data[15:12] != OP_HALT and the state is FETCH, push rsp_data into the FIFO.
  - If rsp_data[15:12] == OP_HALT in FETCH: do not push it, and go to DRAIN next cycle.
  - rsp_valid with outstanding == 0 is discarded and changes no state.
- State DRAIN:
  - req_valid = 0.
  - Responses still outstanding are consumed and discarded; they are fetched past the HALT and must not execute.
  - Already-buffered words are still delivered.
  - Move to HALTED when outstanding == 0 and the FIFO is empty.
- State HALTED: halted = 1. start reloads pc and moves to FETCH.
- Same-cycle request issue and response: outstanding is unchanged.
- Same-cycle push and pop: fifo_count is unchanged.
- The credit rule guarantees a push never meets a full FIFO. Overflow is a design error.
- Pop occurs on instr_valid && instr_ready.
- instr_valid = FIFO not empty. The FIFO write is registered, so a word returned at cycle N is visible at cycle N+1.
- Latency with a 1-cycle memory and req_ready = 1:
  - start at cycle 0;
  - req_valid at cycle 1;
  - rsp at cycle 2;
  - instr_valid at cycle 3.
- Throughput: one instruction per cycle in steady state when memory latency < DEPTH.

Decomposition:
- Package instr_fetch_pkg holds:
  - OPCODE_W = 4;
  - OP_NOP = 4'h0 and OP_HALT = 4'hF;
  - NOP_WORD = 16'h0000;
  - fetch_state_t enum {IDLE, FETCH, DRAIN, HALTED}.
- Sub-module instr_fifo: synchronous FIFO, parameters WIDTH and DEPTH. Ports push, pop, wdata, rdata, count, empty, full, clear. Async reset.
- The FSM, pc and outstanding counter stay in the top module.

Test Plan:
- Basic fetch: start with start_pc = 8'h10; memory returns 16'h1248, 16'h2248, 16'h3248 at 1-cycle latency; instr_ready = 1.
  - req_addr goes 10, 11, 12.
  - instruction shows the three words at cycles 3, 4, 5, then 16'h0000.
- Back-pressure: instr_ready = 0 and memory always ready.
  - Exactly 4 requests issue, then req_valid stays 0.
  - Raising instr_ready gives one pop per cycle, each pop freeing one credit.
  - No word is lost or duplicated.
- HALT: memory at addresses 0..2 holds 16'h1248, 16'hF000, 16'h2248, with 3-cycle latency.
  - Only 16'h1248 reaches the output.
  - The word after HALT is discarded.
  - halted = 1 after outstanding reaches 0; a subsequent start resumes from the new start_pc.
- Wrap and stall: start_pc = 8'hFE with req_ready toggling.
  - req_addr sequence is FE, FF, 00, 01.
  - pc holds while req_ready = 0.
- Reset mid-fetch: assert rst asynchronously with 2 outstanding and 1 buffered word.
  - All outputs are 0 immediately.
  - Late rsp_valid pulses after reset are ignored: instr_valid stays 0 and the state stays IDLE.
- Spurious response: rsp_valid = 1 in IDLE with data 16'h1248 → FIFO stays empty and instruction stays 16'h0000.
